// File: rtl/bram_vram.sv
`default_nettype none
// ============================================================================
//  Module      : bram_vram
//  Description : Single-port synchronous 8 KiB video RAM for the Game Boy PPU
//                (CPU map 0x8000-0x9FFF). Holds tile data and the BG/window
//                tile maps. After every reset an internal sequencer zero-fills
//                the whole array before external accesses are honoured.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W          address width, depth = 2**ADDR_W bytes (default 13)
//    DATA_W          data width (default 8)
//    CLEAR_ON_RESET  1: zero-fill the array after reset, 0: skip the fill
//
//  Ports
//    clka   in   1       clock, all logic on its rising edge
//    rst_n  in   1       synchronous active-low reset
//    addra  in   ADDR_W  byte address (vram_a[12:0])
//    dina   in   DATA_W  write data
//    wea    in   1       write enable, sampled at the clka edge
//    douta  out  DATA_W  registered read data (read-first on collisions)
//    busy   out  1       high while in reset or clearing; access is ignored
//
//  Configuration macro
//    BRAM_VRAM_OUTREG_EN  adds an output pipeline register after the array
//                         read; read latency becomes 2 cycles. busy timing
//                         is unchanged.
// ============================================================================
module bram_vram #(
    parameter int ADDR_W         = 13,
    parameter int DATA_W         = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    input  logic              wea,
    output logic [DATA_W-1:0] douta,
    output logic              busy
);

    localparam int                C_DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] C_PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] C_PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Storage: one plain array with a synchronous write and a registered read
    // so it maps onto a single block RAM.
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] mem [0:C_DEPTH-1];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q,   ptr_d;
    logic              busy_q,  busy_d;

    // Shared write port, steered either by the clear sequencer or the PPU.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] rd_data_q;

    // ------------------------------------------------------------------------
    // Next-state and write-port steering
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_addr  = addra;
        mem_wdata = dina;

        case (state_q)
            ST_CLEAR: begin
                if (CLEAR_ON_RESET != 0) begin
                    mem_we    = 1'b1;
                    mem_addr  = ptr_q;
                    mem_wdata = '0;
                    ptr_d     = ptr_q + C_PTR_ONE;
                    // Leave on the same edge that writes the last location.
                    if (ptr_q == C_PTR_LAST) begin
                        state_d = ST_READY;
                        busy_d  = 1'b0;
                    end
                end else begin
                    // Fill disabled: contents survive, go straight to READY.
                    state_d = ST_READY;
                    busy_d  = 1'b0;
                end
            end
            ST_READY: begin
                mem_we = wea;
            end
            default: begin
                state_d = ST_CLEAR;
                busy_d  = 1'b1;
            end
        endcase

        // The array is never touched while reset is asserted.
        if (!rst_n) begin
            mem_we = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------------
    always_ff @(posedge clka) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    // ------------------------------------------------------------------------
    // Array write
    // ------------------------------------------------------------------------
    always_ff @(posedge clka) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Registered read. Sampling the array with a non-blocking assignment on
    // the same edge as the write gives read-first behaviour on collisions.
    // The output is forced to zero during reset and while clearing.
    // ------------------------------------------------------------------------
    always_ff @(posedge clka) begin
        if (!rst_n || busy_q) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[addra];
        end
    end

`ifdef BRAM_VRAM_OUTREG_EN
    // Optional output pipeline stage; held at zero while busy.
    logic [DATA_W-1:0] dout_pipe_q;

    always_ff @(posedge clka) begin
        if (!rst_n || busy_q) begin
            dout_pipe_q <= '0;
        end else begin
            dout_pipe_q <= rd_data_q;
        end
    end

    assign douta = dout_pipe_q;
`else
    assign douta = rd_data_q;
`endif

    assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_vram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_vram
//  Description : Self-checking bench for bram_vram. A byte-array reference
//                model predicts every read; predictions go into a queue that
//                a separate monitor drains when each read result is due.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_vram;

`ifdef BRAM_VRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH     = 8192;
    localparam int FILL_CYCS = 8192;

    logic        clk;
    logic        rst_n;
    logic [12:0] addra;
    logic [7:0]  dina;
    logic        wea;
    logic [7:0]  douta;
    logic        busy;

    bram_vram #(
        .ADDR_W         (13),
        .DATA_W         (8),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clka  (clk),
        .rst_n (rst_n),
        .addra (addra),
        .dina  (dina),
        .wea   (wea),
        .douta (douta),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [12:0] addr;
        logic [7:0]  val;
    } exp_t;

    exp_t        exp_q [$];
    logic [7:0]  ref_mem [DEPTH];
    logic [12:0] wr_addrs [$];
    int          cyc   = 0;
    int          tests = 0;
    int          fails = 0;

    // ------------------------------------------------------------------------
    // Monitor: counts edges and checks every read result that falls due.
    // ------------------------------------------------------------------------
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            tests++;
            if (e.due != cyc || douta !== e.val) begin
                fails++;
                $display("FAIL read@%04h: douta=%02h expected=%02h (due %0d, now %0d)",
                         e.addr, douta, e.val, e.due, cyc);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One external access issued at a negedge. The model predicts the old
    // byte (read-first) and then applies the write.
    task automatic access(input logic [12:0] a, input logic w, input logic [7:0] d);
        exp_t e;
        addra = a;
        wea   = w;
        dina  = d;
        e.due  = cyc + LAT;
        e.addr = a;
        e.val  = ref_mem[a];
        exp_q.push_back(e);
        if (w) ref_mem[a] = d;
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    endtask

    // Release reset and count negedge samples of busy=1. Writes to 0x0010
    // are attempted throughout and must be ignored.
    task automatic fill_count(output int n, output int nonzero);
        n       = 0;
        nonzero = 0;
        rst_n   = 1'b1;
        addra   = 13'h0010;
        dina    = 8'hFF;
        wea     = 1'b1;
        while (busy === 1'b1 && n < FILL_CYCS + 2000) begin
            if (douta !== 8'h00) nonzero++;
            n++;
            @(negedge clk);
        end
        wea = 1'b0;
    endtask

    task automatic drain();
        wea = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int nz;
        logic [12:0] a;
        logic        w;
        logic [7:0]  d;

        rst_n = 1'b0;
        addra = '0;
        dina  = '0;
        wea   = 1'b0;
        clear_model();

        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1);
        check("reset_douta", douta, 0);

        fill_count(n, nz);
        check("fill_length", n, FILL_CYCS);
        check("fill_douta_zero", nz, 0);
        check("busy_after_fill", busy, 0);

        // Post-fill reads, including the address attacked while busy.
        access(13'h0000, 1'b0, 8'h00);
        access(13'h0FFF, 1'b0, 8'h00);
        access(13'h1FFF, 1'b0, 8'h00);
        access(13'h0010, 1'b0, 8'h00);

        // Write, read back, overwrite with collision, read back.
        access(13'h1234, 1'b1, 8'hA5);
        access(13'h1234, 1'b0, 8'h00);
        access(13'h1234, 1'b1, 8'h3C);
        access(13'h1234, 1'b0, 8'h00);
        wr_addrs.push_back(13'h1234);

        // Random traffic, mostly in a small window to force collisions.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) a = 13'($urandom_range(0, DEPTH - 1));
            else                          a = 13'h0100 + 13'($urandom_range(0, 31));
            w = ($urandom_range(0, 1) == 1);
            d = 8'($urandom_range(1, 255));
            if (w && wr_addrs.size() < 24) wr_addrs.push_back(a);
            access(a, w, d);
        end
        drain();

        // Leave a known non-zero byte on douta, then reset mid-access.
        access(13'h1234, 1'b1, 8'h5A);
        access(13'h1234, 1'b0, 8'h00);
        drain();
        check("pre_reset_douta", douta, 8'h5A);

        rst_n = 1'b0;
        @(negedge clk);
        check("midaccess_reset_douta", douta, 0);
        check("midaccess_reset_busy", busy, 1);

        // Start a fill, abort it at cycle 4000, then time the full restart.
        rst_n = 1'b1;
        repeat (4000) @(negedge clk);
        check("busy_mid_fill", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        fill_count(n, nz);
        check("refill_length", n, FILL_CYCS);
        check("refill_douta_zero", nz, 0);
        clear_model();

        for (int i = 0; i < wr_addrs.size(); i++) begin
            access(wr_addrs[i], 1'b0, 8'h00);
        end
        access(13'h0010, 1'b0, 8'h00);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, cycle=%0d expected<30000", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
